plab4_net_router_output_ctrl_arbiter_tp: RTL

Output-side counterpart of the timing-protected router input control. It collects the 3-bit `reqs` vector from the three input controls (one bit per input port) that target this output, and returns a one-hot `grants` vector plus the crossbar select. It also owns the router's time-multiplexed domain schedule: fixed-length epochs alternate between domain 0 and domain 1, and a guard window closes each epoch. Arbitration state is kept separately per domain, so one domain's traffic can never change the timing seen by the other.

---
 rtl/plab4_net_tp_pkg.sv | 34 +++
 rtl/plab4_net_tp_rr_arb3.sv | 58 +++++
 rtl/plab4_net_router_output_ctrl_arbiter_tp.sv | 72 +++++++
 3 files changed

// File: rtl/plab4_net_tp_pkg.sv
// ----------------------------------------------------------------------------
// plab4_net_tp_pkg
// Shared domain, port-index and width definitions for the timing-protected router.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package plab4_net_tp_pkg;

  localparam logic DOMAIN_D0 = 1'b0;
  localparam logic DOMAIN_D1 = 1'b1;

  localparam int PORT_TERM = 0;
  localparam int PORT_WEST = 1;
  localparam int PORT_EAST = 2;

  localparam int GRANT_W = 3;
  localparam int SEL_W   = 2;

  typedef logic [GRANT_W-1:0] grant_t;
  typedef logic [SEL_W-1:0]   sel_t;

  // One-hot grant to crossbar select; an empty grant maps to port 0.
  function automatic sel_t grant_to_sel(input grant_t g);
    sel_t s;
    s = '0;
    if (g[PORT_WEST]) s = SEL_W'(PORT_WEST);
    if (g[PORT_EAST]) s = SEL_W'(PORT_EAST);
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/plab4_net_tp_rr_arb3.sv
// ----------------------------------------------------------------------------
// plab4_net_tp_rr_arb3
// Three-input round-robin arbiter with one private priority register.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module plab4_net_tp_rr_arb3
  import plab4_net_tp_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   en,
  input  grant_t reqs,
  output grant_t grants
);

  grant_t r_prio;
  grant_t w_grants;

  // Scan circularly upward from the one-hot priority position.
  always_comb begin
    w_grants = '0;
    if (en) begin
      case (r_prio)
        3'b010: begin
          if      (reqs[1]) w_grants = 3'b010;
          else if (reqs[2]) w_grants = 3'b100;
          else if (reqs[0]) w_grants = 3'b001;
        end
        3'b100: begin
          if      (reqs[2]) w_grants = 3'b100;
          else if (reqs[0]) w_grants = 3'b001;
          else if (reqs[1]) w_grants = 3'b010;
        end
        default: begin
          if      (reqs[0]) w_grants = 3'b001;
          else if (reqs[1]) w_grants = 3'b010;
          else if (reqs[2]) w_grants = 3'b100;
        end
      endcase
    end
  end

  // The winner's successor becomes highest priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio <= 3'b001;
    end else if (w_grants != '0) begin
      r_prio <= {w_grants[1:0], w_grants[2]};
    end
  end

  assign grants = w_grants;

endmodule

`default_nettype wire

// File: rtl/plab4_net_router_output_ctrl_arbiter_tp.sv
// ----------------------------------------------------------------------------
// plab4_net_router_output_ctrl_arbiter_tp
// Output arbiter owning the two-domain epoch schedule, with per-domain priority.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module plab4_net_router_output_ctrl_arbiter_tp
  import plab4_net_tp_pkg::*;
#(
  parameter int p_epoch_len = 8,
  parameter int p_guard     = 1
) (
  input  logic   clk,
  input  logic   reset_n,
  input  grant_t reqs,
  input  logic   out_rdy_d0,
  input  logic   out_rdy_d1,
  output grant_t grants,
  output sel_t   sel,
  output logic   domain,
  output logic   guard
);

  localparam int c_cnt_nbits = $clog2(p_epoch_len);
  localparam logic [c_cnt_nbits-1:0] c_cnt_last    = c_cnt_nbits'(p_epoch_len - 1);
  localparam logic [c_cnt_nbits:0]   c_guard_start = (c_cnt_nbits + 1)'(p_epoch_len - p_guard);

  logic [c_cnt_nbits-1:0] r_cnt;
  logic                   r_domain;
  logic                   w_guard;
  logic [1:0]             w_rdy;
  grant_t                 w_dom_grants [2];

  // The schedule advances on time alone; traffic never perturbs it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_domain <= DOMAIN_D0;
    end else if (r_cnt == c_cnt_last) begin
      r_cnt    <= '0;
      r_domain <= ~r_domain;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  assign w_guard = ({1'b0, r_cnt} >= c_guard_start);
  assign w_rdy   = {out_rdy_d1, out_rdy_d0};

  // reset_n in the enable kills a grant as soon as reset asserts.
  for (genvar d = 0; d < 2; d++) begin : g_dom
    logic w_en;
    assign w_en = reset_n & ~w_guard & w_rdy[d] & (r_domain == 1'(d));

    plab4_net_tp_rr_arb3 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (w_en),
      .reqs    (reqs),
      .grants  (w_dom_grants[d])
    );
  end

  assign grants = w_dom_grants[0] | w_dom_grants[1];
  assign sel    = grant_to_sel(grants);
  assign domain = r_domain;
  assign guard  = w_guard;

endmodule

`default_nettype wire
